// File: rtl/selen_fetch_pkg.sv
// Shared types, constants and helpers for the Selen instruction fetch stage.
package selen_fetch_pkg;

    localparam int INSTR_W      = 32;
    localparam int PC_STEP      = 4;
    localparam int FETCH_ADDR_W = 32;

    typedef enum logic [1:0] {
        FS_RESET = 2'd0,
        FS_RUN   = 2'd1,
        FS_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0]      instr;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
        if (en && (value != 32'hFFFF_FFFF)) begin
            return value + 32'd1;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/core_fetch_fifo.sv
// Synchronous FIFO with flush; holds prefetched words and the per-request PC tags.
module core_fetch_fifo
    import selen_fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    parameter int  CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  entry_t           data_i,
    input  logic             pop_i,
    output entry_t           data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s) && !flush_i;
    assign data_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Pointers and occupancy; flush empties the queue and overrides push/pop.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Storage array; contents are only observed while the count says they are valid.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/core_fetch.sv
// Selen instruction fetch stage: credit-limited requests, prefetch FIFO, redirect with stale drop.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module core_fetch
    import selen_fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(32'h0000_0200),
    parameter int                FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               i_req_val,
    output logic [ADDR_W-1:0]  i_req_addr,
    input  logic               i_req_ack,
    input  logic               i_ack_val,
    input  logic [INSTR_W-1:0] i_ack_data,
    input  logic               redirect_val,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_val,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_rdy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_drop_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;
    typedef logic [ADDR_W-1:0] tag_t;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [SUM_W-1:0]  outstanding_s;
    logic [SUM_W-1:0]  in_use_s;
    logic              req_take_s, resp_s, drop_s, live_resp_s, pop_s;
    entry_t            pf_head_s, pf_push_data_s;
    tag_t              tag_head_s;
    logic [CNT_W-1:0]  pf_count_s, tag_count_s;
    logic              pf_empty_s, pf_full_s, tag_empty_s, tag_full_s;
    logic              unused_s;

    // Live tags plus responses still owed to a pre-redirect request.
    assign outstanding_s = SUM_W'(tag_count_s) + SUM_W'(drop_cnt_q);
    assign in_use_s      = outstanding_s + SUM_W'(pf_count_s);

    assign i_req_val   = (state_q == FS_RUN) && (in_use_s < SUM_W'(FIFO_DEPTH)) &&
                         !tag_full_s && !pf_full_s;
    assign i_req_addr  = pc_q;
    assign req_take_s  = i_req_val && i_req_ack;
    assign resp_s      = i_ack_val && (outstanding_s != '0);
    assign drop_s      = resp_s && (drop_cnt_q != '0);
    assign live_resp_s = resp_s && !drop_s && !tag_empty_s;

    assign instr_val   = !pf_empty_s;
    assign instr_data  = pf_head_s.instr;
    assign instr_pc    = pf_head_s.pc;
    assign pop_s       = instr_val && instr_rdy;

    assign pf_push_data_s.instr = i_ack_data;
    assign pf_push_data_s.pc    = tag_head_s;
    assign unused_s             = ^redirect_pc[1:0];

    // Next-state logic for the fetch FSM, PC and stale-response counter.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            FS_RESET: state_d = FS_RUN;
            FS_RUN:   state_d = FS_RUN;
            FS_FLUSH: state_d = FS_RUN;
            default:  state_d = FS_RESET;
        endcase
        if (redirect_val) begin
            state_d    = FS_FLUSH;
            pc_d       = {redirect_pc[ADDR_W-1:2], 2'b00};
            drop_cnt_d = CNT_W'(outstanding_s + SUM_W'(req_take_s) - SUM_W'(resp_s));
        end else begin
            if (req_take_s) begin
                pc_d = pc_q + ADDR_W'(PC_STEP);
            end else begin
                pc_d = pc_q;
            end
            if (drop_s) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FS_RESET;
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Redirect flushes both queues; a same-cycle decode pop is discarded with them.
    core_fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_prefetch (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (redirect_val),
        .push_i  (live_resp_s),
        .data_i  (pf_push_data_s),
        .pop_i   (pop_s),
        .data_o  (pf_head_s),
        .count_o (pf_count_s),
        .empty_o (pf_empty_s),
        .full_o  (pf_full_s)
    );

    core_fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (tag_t)
    ) u_tag_queue (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (redirect_val),
        .push_i  (req_take_s),
        .data_i  (pc_q),
        .pop_i   (live_resp_s),
        .data_o  (tag_head_s),
        .count_o (tag_count_s),
        .empty_o (tag_empty_s),
        .full_o  (tag_full_s)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_drop_q, perf_stall_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= 32'd0;
            perf_drop_q  <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            perf_fetch_q <= sat_inc32(perf_fetch_q, req_take_s);
            perf_drop_q  <= sat_inc32(perf_drop_q, resp_s && (drop_s || redirect_val));
            perf_stall_q <= sat_inc32(perf_stall_q, i_req_val && !i_req_ack);
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_drop_cnt  = perf_drop_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_core_fetch.sv
// Self-checking bench for core_fetch: directed tables/sequences plus a random run
// against an epoch-tagged memory and program-order model.
module tb_core_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_val, i_req_ack, i_ack_val, redirect_val, instr_val, instr_rdy;
    logic [31:0] i_req_addr, i_ack_data, redirect_pc, instr_data, instr_pc;
    logic        w_req_val, w_ack_val, w_instr_val;
    logic [31:0] w_req_addr, w_ack_data, w_instr_data, w_instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] pf_a, pd_a, ps_a, pf_b, pd_b, ps_b;
`endif

    always #5 clk = ~clk;

    core_fetch dut (
        .clk(clk), .rst(rst),
        .i_req_val(i_req_val), .i_req_addr(i_req_addr), .i_req_ack(i_req_ack),
        .i_ack_val(i_ack_val), .i_ack_data(i_ack_data),
        .redirect_val(redirect_val), .redirect_pc(redirect_pc),
        .instr_val(instr_val), .instr_data(instr_data), .instr_pc(instr_pc),
        .instr_rdy(instr_rdy)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(pf_a), .perf_drop_cnt(pd_a), .perf_stall_cnt(ps_a)
`endif
    );

    core_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst),
        .i_req_val(w_req_val), .i_req_addr(w_req_addr), .i_req_ack(1'b1),
        .i_ack_val(w_ack_val), .i_ack_data(w_ack_data),
        .redirect_val(1'b0), .redirect_pc(32'h0000_0000),
        .instr_val(w_instr_val), .instr_data(w_instr_data), .instr_pc(w_instr_pc),
        .instr_rdy(1'b1)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(pf_b), .perf_drop_cnt(pd_b), .perf_stall_cnt(ps_b)
`endif
    );

    typedef struct { logic [31:0] addr; int epoch; } mreq_t;
    typedef struct {
        bit ack; bit rdy; bit exp_rv; logic [31:0] exp_ra; bit exp_iv; logic [31:0] exp_ipc;
    } vec_t;

    mreq_t       memq[$];
    int          epoch, buffered, takes, checks, errors, w_cnt;
    bit          run_ok, w_pend;
    logic [31:0] fetch_pc, exp_pc, w_pend_addr;
    logic [31:0] w_pcs [3];
    vec_t        tbl [8];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        rst = 1'b1; i_req_ack = 1'b0; i_ack_val = 1'b0; redirect_val = 1'b0;
        instr_rdy = 1'b0; w_ack_val = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("rst_req_val", 32'(i_req_val), 32'd0);
            chk("rst_instr_val", 32'(instr_val), 32'd0);
        end
        memq.delete();
        epoch++; buffered = 0; run_ok = 1'b0;
        fetch_pc = 32'h0000_0200; exp_pc = 32'h0000_0200;
        w_pend = 1'b0; w_cnt = 0;
        for (int i = 0; i < 3; i++) w_pcs[i] = 32'hDEAD_BEEF;
    endtask

    task automatic drive(input bit ack, input bit rdy, input bit redir,
                         input logic [31:0] rpc, input bit resp);
        @(negedge clk);
        rst = 1'b0;
        i_req_ack = ack; instr_rdy = rdy; redirect_val = redir; redirect_pc = rpc;
        if (resp && memq.size() > 0) begin
            i_ack_val = 1'b1; i_ack_data = word_of(memq[0].addr);
        end else begin
            i_ack_val = 1'b0; i_ack_data = $urandom;
        end
        w_ack_val  = w_pend;
        w_ack_data = w_pend ? word_of(w_pend_addr) : 32'h0;
        #1;
    endtask

    // Model checks for the current cycle, then the model absorbs this cycle's events.
    task automatic commit();
        mreq_t e;
        chk("req_val", 32'(i_req_val), 32'(run_ok && (memq.size() + buffered < 4)));
        if (i_req_val) chk("req_addr", i_req_addr, fetch_pc);
        chk("instr_val", 32'(instr_val), 32'(buffered > 0));
        if (instr_val && instr_rdy && !redirect_val) begin
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr_data", instr_data, word_of(exp_pc));
            exp_pc += 32'd4; buffered--;
        end
        if (i_ack_val) begin
            e = memq.pop_front();
            if (e.epoch == epoch && !redirect_val) buffered++;
        end
        if (i_req_val && i_req_ack) begin
            memq.push_back('{fetch_pc, epoch});
            fetch_pc += 32'd4; takes++;
        end
        if (redirect_val) begin
            epoch++; buffered = 0;
            fetch_pc = {redirect_pc[31:2], 2'b00}; exp_pc = fetch_pc;
        end
        run_ok = !redirect_val;
        if (w_instr_val && w_cnt < 3) begin
            chk("wrap_data", w_instr_data, word_of(w_instr_pc));
            w_pcs[w_cnt] = w_instr_pc; w_cnt++;
        end
        w_pend = w_req_val; w_pend_addr = w_req_addr;
        @(posedge clk);
    endtask

    task automatic wait_instr(input string name, input logic [31:0] exp, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            if (instr_val) begin
                chk(name, instr_pc, exp); seen = 1'b1;
            end
            commit();
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_req(input string name, input logic [31:0] exp, input int budget,
                            input bit rdy);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            drive(1'b1, rdy, 1'b0, 32'h0, 1'b1);
            if (i_req_val) begin
                chk(name, i_req_addr, exp); seen = 1'b1;
            end
            commit();
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; epoch = 0; takes = 0;
        rst = 1'b1; i_req_ack = 1'b0; i_ack_val = 1'b0; i_ack_data = 32'h0;
        redirect_val = 1'b0; redirect_pc = 32'h0; instr_rdy = 1'b0;
        w_ack_val = 1'b0; w_ack_data = 32'h0;

        // Streaming with 1-cycle memory latency: decode sees 0x200 from cycle 3.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h204, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h208, 1'b1, 32'h200};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h20C, 1'b1, 32'h204};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h210, 1'b1, 32'h208};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h214, 1'b1, 32'h20C};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h218, 1'b1, 32'h210};
        apply_reset(2);
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].ack, tbl[i].rdy, 1'b0, 32'h0, 1'b1);
            chk("t1_req_val", 32'(i_req_val), 32'(tbl[i].exp_rv));
            if (tbl[i].exp_rv) chk("t1_req_addr", i_req_addr, tbl[i].exp_ra);
            chk("t1_instr_val", 32'(instr_val), 32'(tbl[i].exp_iv));
            if (tbl[i].exp_iv) chk("t1_instr_pc", instr_pc, tbl[i].exp_ipc);
            commit();
        end

        // Wrapping PC on the second instance, run alongside the table above.
        chk("t5_wrap_pc0", w_pcs[0], 32'hFFFF_FFF8);
        chk("t5_wrap_pc1", w_pcs[1], 32'hFFFF_FFFC);
        chk("t5_wrap_pc2", w_pcs[2], 32'h0000_0000);

        // Decode stalled: exactly four requests, then resume at 0x210.
        apply_reset(2);
        takes = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            commit();
        end
        chk("t2_req_count", takes, 32'd4);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t2_req_stall", 32'(i_req_val), 32'd0);
        commit();
        wait_req("t2_resume_addr", 32'h210, 10, 1'b1);

        // Redirect with two outstanding requests.
        apply_reset(2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            commit();
        end
        drive(1'b0, 1'b1, 1'b1, 32'h1003, 1'b0);
        commit();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t3_flush_req_val", 32'(i_req_val), 32'd0);
        commit();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t3_req_val", 32'(i_req_val), 32'd1);
        chk("t3_req_addr", i_req_addr, 32'h1000);
        commit();
        wait_instr("t3_first_pc", 32'h1000, 20);

        // Redirect coinciding with a request ack and a response.
        apply_reset(2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            commit();
        end
        drive(1'b1, 1'b1, 1'b1, 32'h2000, 1'b1);
        chk("t4_req_val", 32'(i_req_val), 32'd1);
        chk("t4_resp", 32'(i_ack_val), 32'd1);
        commit();
        wait_instr("t4_first_pc", 32'h2000, 20);
        wait_instr("t4_second_pc", 32'h2004, 20);

        // Reset with a full prefetch FIFO, then restart at RESET_PC.
        apply_reset(2);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            commit();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t6_full_val", 32'(instr_val), 32'd1);
        commit();
        apply_reset(1);
        wait_req("t6_restart_addr", 32'h200, 5, 1'b1);

        // Random traffic against the model.
        apply_reset(2);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(999) < 3) apply_reset(1 + $urandom_range(2));
            drive($urandom_range(99) < 70, $urandom_range(99) < 70,
                  $urandom_range(99) < 3, $urandom, $urandom_range(99) < 60);
            commit();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
